// File: rtl/aes_cbc_stream_framer.sv
// Serializes AES-CBC commands (key, IV, text blocks) into an AXI-stream frame
// for the downstream CBC cipher core; fields go out least-significant beat first.
module aes_cbc_stream_framer #(
  parameter int unsigned M_AXIS_WIDTH = 64
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Cmd_valid,
  output logic                      Cmd_ready,
  input  logic [255:0]              Cmd_key,
  input  logic [127:0]              Cmd_iv,
  input  logic                      Cmd_encrypt,
  input  logic [15:0]               Cmd_blocks,
  input  logic                      Blk_valid,
  output logic                      Blk_ready,
  input  logic [127:0]              Blk_data,
  output logic                      M_axis_tvalid,
  input  logic                      M_axis_tready,
  output logic [M_AXIS_WIDTH-1:0]   M_axis_tdata,
  output logic [M_AXIS_WIDTH/8-1:0] M_axis_tkeep,
  output logic                      M_axis_tlast,
  output logic                      M_axis_tuser,
  output logic                      Busy,
  output logic                      Err_zero
);

  localparam int unsigned MW     = M_AXIS_WIDTH;
  localparam int unsigned KEEP_W = MW / 8;
  localparam int unsigned KW     = 256 / MW;
  localparam int unsigned BW     = 128 / MW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_IV   = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;

  localparam logic [2:0] KEY_LAST = 3'(KW - 1);
  localparam logic [2:0] BLK_LAST = 3'(BW - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [255:0]      key_q, key_d;
  logic [127:0]      iv_q, iv_d;
  logic [127:0]      blk_q, blk_d;
  logic              enc_q, enc_d;
  logic [15:0]       rem_q, rem_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              tvalid_q, tvalid_d;
  logic [MW-1:0]     tdata_q, tdata_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;

  logic cmd_hs;
  logic blk_hs;
  logic beat_hs;

  // Readies are forced low while reset is asserted so nothing is accepted then.
  assign Cmd_ready = (state_q == S_IDLE) && !Rst;
  assign Blk_ready = (state_q == S_LOAD) && !Rst;

  assign cmd_hs  = Cmd_valid && Cmd_ready;
  assign blk_hs  = Blk_valid && Blk_ready;
  assign beat_hs = tvalid_q && M_axis_tready;

  // Next-state, payload capture and next registered stream outputs.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    key_d   = key_q;
    iv_d    = iv_q;
    blk_d   = blk_q;
    enc_d   = enc_q;
    rem_d   = rem_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          if (Cmd_blocks != 16'd0) begin
            key_d   = Cmd_key;
            iv_d    = Cmd_iv;
            enc_d   = Cmd_encrypt;
            rem_d   = Cmd_blocks;
            beat_d  = 3'd0;
            state_d = S_KEY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_KEY: begin
        if (beat_hs) begin
          if (beat_q == KEY_LAST) begin
            beat_d  = 3'd0;
            state_d = S_IV;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      S_IV: begin
        if (beat_hs) begin
          if (beat_q == BLK_LAST) begin
            beat_d  = 3'd0;
            state_d = S_LOAD;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      S_LOAD: begin
        if (blk_hs) begin
          blk_d   = Blk_data;
          beat_d  = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_hs) begin
          if (beat_q == BLK_LAST) begin
            beat_d  = 3'd0;
            rem_d   = rem_q - 16'd1;
            state_d = (rem_q == 16'd1) ? S_IDLE : S_LOAD;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 3'd0;
      end
    endcase

    // Stream outputs are registered from the next state so they stay stable under stall.
    tvalid_d = (state_d == S_KEY) || (state_d == S_IV) || (state_d == S_DATA);
    tdata_d  = '0;
    case (state_d)
      S_KEY:   tdata_d = MW'(key_d >> (32'(beat_d) * MW));
      S_IV:    tdata_d = MW'(iv_d >> (32'(beat_d) * MW));
      S_DATA:  tdata_d = MW'(blk_d >> (32'(beat_d) * MW));
      default: tdata_d = '0;
    endcase
    tkeep_d = tvalid_d ? {KEEP_W{1'b1}} : {KEEP_W{1'b0}};
    tlast_d = (state_d == S_DATA) && (beat_d == BLK_LAST) && (rem_d == 16'd1);
    tuser_d = tvalid_d && enc_d;
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      beat_q   <= 3'd0;
      key_q    <= '0;
      iv_q     <= '0;
      blk_q    <= '0;
      enc_q    <= 1'b0;
      rem_q    <= 16'd0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      blk_q    <= blk_d;
      enc_q    <= enc_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign M_axis_tvalid = tvalid_q;
  assign M_axis_tdata  = tdata_q;
  assign M_axis_tkeep  = tkeep_q;
  assign M_axis_tlast  = tlast_q;
  assign M_axis_tuser  = tuser_q;
  assign Busy          = busy_q;
  assign Err_zero      = err_q;

endmodule

// File: tb/tb_aes_cbc_stream_framer.sv
// Directed bench for aes_cbc_stream_framer: 64-bit and 128-bit beat instances,
// hand-computed beat sequences, stall, zero-block, busy-command and mid-frame reset.
module tb_aes_cbc_stream_framer;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
    logic         user;
  } beat_t;

  localparam logic [255:0] K1  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [63:0] ENC1_BEATS [8] = '{
    64'h2d9810a30914dff4, 64'h1f352c073b6108d7, 64'h2b73aef0857d7781, 64'h603deb1015ca71be,
    64'h08090a0b0c0d0e0f, 64'h0001020304050607, 64'he93d7e117393172a, 64'h6bc1bee22e409f96};

  localparam logic [255:0] K2  = 256'h44444444444444443333333333333333_22222222222222221111111111111111;
  localparam logic [127:0] IV2 = 128'hbbbbbbbbbbbbbbbbaaaaaaaaaaaaaaaa;
  localparam logic [127:0] D2 [3] = '{128'h0123456789abcdeffedcba9876543210,
                                      128'h00000000000000011111111111111110,
                                      128'hdeadbeefcafef00d5555aaaa5555aaaa};
  localparam logic [255:0] K3  = 256'ha3a3a3a3a3a3a3a3a2a2a2a2a2a2a2a2_a1a1a1a1a1a1a1a1a0a0a0a0a0a0a0a0;
  localparam logic [255:0] K4  = 256'hb3b3b3b3b3b3b3b3b2b2b2b2b2b2b2b2_b1b1b1b1b1b1b1b1b0b0b0b0b0b0b0b0;
  localparam logic [127:0] IV3 = 128'hc1c1c1c1c1c1c1c1c0c0c0c0c0c0c0c0;
  localparam logic [127:0] IV4 = 128'hd1d1d1d1d1d1d1d1d0d0d0d0d0d0d0d0;
  localparam logic [127:0] DA  = 128'he1e1e1e1e1e1e1e1e0e0e0e0e0e0e0e0;
  localparam logic [127:0] DB  = 128'hf1f1f1f1f1f1f1f1f0f0f0f0f0f0f0f0;
  localparam logic [127:0] X0  = 128'h11223344556677888877665544332211;
  localparam logic [127:0] X1  = 128'h99aabbccddeeff00ffeeddccbbaa9988;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid1, cmd_valid2;
  logic [255:0] cmd_key;
  logic [127:0] cmd_iv;
  logic         cmd_enc;
  logic [15:0]  cmd_blocks;
  logic         blk_valid1, blk_valid2;
  logic [127:0] blk_data;
  logic         tready1, tready2;
  logic         toggle = 1'b0;

  logic         cmd_ready1, blk_ready1, tvalid1, tlast1, tuser1, busy1, err1;
  logic [63:0]  tdata1;
  logic [7:0]   tkeep1;
  logic         cmd_ready2, blk_ready2, tvalid2, tlast2, tuser2, busy2, err2;
  logic [127:0] tdata2;
  logic [15:0]  tkeep2;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t got64[$];
  beat_t got128[$];
  beat_t exp_q[$];
  int    n_last1 = 0, n_blk1 = 0, n_err1 = 0;
  int    keep_viol1 = 0, keep_viol2 = 0, stall_viol = 0, busy_viol = 0;
  logic  stall_pend = 1'b0;
  logic [65:0] stall_snap = '0;

  always #5 clk = ~clk;

  aes_cbc_stream_framer #(.M_AXIS_WIDTH(64)) u_dut (
    .Clk(clk), .Rst(rst),
    .Cmd_valid(cmd_valid1), .Cmd_ready(cmd_ready1), .Cmd_key(cmd_key), .Cmd_iv(cmd_iv),
    .Cmd_encrypt(cmd_enc), .Cmd_blocks(cmd_blocks),
    .Blk_valid(blk_valid1), .Blk_ready(blk_ready1), .Blk_data(blk_data),
    .M_axis_tvalid(tvalid1), .M_axis_tready(tready1), .M_axis_tdata(tdata1),
    .M_axis_tkeep(tkeep1), .M_axis_tlast(tlast1), .M_axis_tuser(tuser1),
    .Busy(busy1), .Err_zero(err1)
  );

  aes_cbc_stream_framer #(.M_AXIS_WIDTH(128)) u_dut128 (
    .Clk(clk), .Rst(rst),
    .Cmd_valid(cmd_valid2), .Cmd_ready(cmd_ready2), .Cmd_key(cmd_key), .Cmd_iv(cmd_iv),
    .Cmd_encrypt(cmd_enc), .Cmd_blocks(cmd_blocks),
    .Blk_valid(blk_valid2), .Blk_ready(blk_ready2), .Blk_data(blk_data),
    .M_axis_tvalid(tvalid2), .M_axis_tready(tready2), .M_axis_tdata(tdata2),
    .M_axis_tkeep(tkeep2), .M_axis_tlast(tlast2), .M_axis_tuser(tuser2),
    .Busy(busy2), .Err_zero(err2)
  );

  // Monitors record every handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid1 && tready1) begin
        got64.push_back('{data: {64'h0, tdata1}, last: tlast1, user: tuser1});
        if (tkeep1 != 8'hff) keep_viol1 <= keep_viol1 + 1;
        if (tlast1) n_last1 <= n_last1 + 1;
      end
      if (blk_valid1 && blk_ready1) n_blk1 <= n_blk1 + 1;
      if (err1) n_err1 <= n_err1 + 1;
      if (busy1 && cmd_ready1) busy_viol <= busy_viol + 1;
      if (stall_pend && tvalid1 && ({tdata1, tlast1, tuser1} != stall_snap))
        stall_viol <= stall_viol + 1;
      stall_pend <= tvalid1 && !tready1;
      stall_snap <= {tdata1, tlast1, tuser1};
    end else begin
      stall_pend <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && tvalid2 && tready2) begin
      got128.push_back('{data: tdata2, last: tlast2, user: tuser2});
      if (tkeep2 != 16'hffff) keep_viol2 <= keep_viol2 + 1;
    end
  end

  initial begin
    tready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready1 = toggle ? ~tready1 : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit w128, input logic [255:0] key, input logic [127:0] iv,
                          input logic enc, input logic [15:0] blocks);
    bit ok = 1'b0;
    bit rdy;
    cmd_key = key; cmd_iv = iv; cmd_enc = enc; cmd_blocks = blocks;
    if (w128) cmd_valid2 = 1'b1; else cmd_valid1 = 1'b1;
    for (int t = 0; t < 2000 && !ok; t++) begin
      rdy = w128 ? cmd_ready2 : cmd_ready1;
      step();
      if (rdy) ok = 1'b1;
    end
    cmd_valid1 = 1'b0; cmd_valid2 = 1'b0;
    check("cmd_handshake", 128'(ok), 128'(1));
  endtask

  task automatic send_blk(input bit w128, input logic [127:0] d);
    bit ok = 1'b0;
    bit rdy;
    blk_data = d;
    if (w128) blk_valid2 = 1'b1; else blk_valid1 = 1'b1;
    for (int t = 0; t < 2000 && !ok; t++) begin
      rdy = w128 ? blk_ready2 : blk_ready1;
      step();
      if (rdy) ok = 1'b1;
    end
    blk_valid1 = 1'b0; blk_valid2 = 1'b0;
    check("blk_handshake", 128'(ok), 128'(1));
  endtask

  task automatic wait_idle(input bit w128);
    bit ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      if (!(w128 ? busy2 : busy1)) ok = 1'b1;
      else step();
    end
    check("idle_reached", 128'(ok), 128'(1));
  endtask

  task automatic exp_field(input logic [255:0] f, input int bits, input int w,
                           input logic user, input logic last_final);
    logic [127:0] d;
    for (int i = 0; i < bits / w; i++) begin
      d = 128'(f >> (i * w));
      if (w == 64) d[127:64] = 64'h0;
      exp_q.push_back('{data: d, last: last_final && (i == bits / w - 1), user: user});
    end
  endtask

  task automatic check_frame(input string tag, input bit w128, input int base);
    beat_t g;
    int n;
    n = (w128 ? got128.size() : got64.size()) - base;
    check({tag, "_beats"}, 128'(n), 128'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < n) begin
        g = w128 ? got128[base + i] : got64[base + i];
        check($sformatf("%s_data%0d", tag, i), g.data, exp_q[i].data);
        check($sformatf("%s_last%0d", tag, i), 128'(g.last), 128'(exp_q[i].last));
        check($sformatf("%s_user%0d", tag, i), 128'(g.user), 128'(exp_q[i].user));
      end
    end
    exp_q.delete();
  endtask

  initial begin
    int base, lbase, bbase, ebase;
    bit ok;
    rst = 1'b1;
    cmd_valid1 = 1'b0; cmd_valid2 = 1'b0; blk_valid1 = 1'b0; blk_valid2 = 1'b0;
    cmd_key = '0; cmd_iv = '0; cmd_enc = 1'b0; cmd_blocks = '0; blk_data = '0;
    tready2 = 1'b1;
    step(); step();

    // Reset values
    check("rst_cmd_ready", 128'(cmd_ready1), 128'(0));
    check("rst_blk_ready", 128'(blk_ready1), 128'(0));
    check("rst_tvalid",    128'(tvalid1),    128'(0));
    check("rst_tdata",     128'(tdata1),     128'(0));
    check("rst_tkeep",     128'(tkeep1),     128'(0));
    check("rst_tlast",     128'(tlast1),     128'(0));
    check("rst_tuser",     128'(tuser1),     128'(0));
    check("rst_busy",      128'(busy1),      128'(0));
    check("rst_err",       128'(err1),       128'(0));
    rst = 1'b0;
    #1;
    check("ready_after_rst", 128'(cmd_ready1), 128'(1));

    // Single encrypt block, always-ready sink
    base = got64.size(); lbase = n_last1;
    foreach (ENC1_BEATS[i]) exp_q.push_back('{data: {64'h0, ENC1_BEATS[i]}, last: (i == 7), user: 1'b1});
    send_cmd(0, K1, IV1, 1'b1, 16'd1);
    check("latency_tvalid", 128'(tvalid1), 128'(1));
    check("latency_tdata",  128'(tdata1),  128'(64'h2d9810a30914dff4));
    check("latency_busy",   128'(busy1),   128'(1));
    check("latency_cmd_rdy", 128'(cmd_ready1), 128'(0));
    send_blk(0, D1);
    wait_idle(0);
    check_frame("enc1", 0, base);
    check("enc1_tlast_count", 128'(n_last1 - lbase), 128'(1));
    check("idle_tdata", 128'(tdata1), 128'(0));
    check("idle_tkeep", 128'(tkeep1), 128'(0));

    // Three decrypt blocks, sink ready toggling
    base = got64.size(); lbase = n_last1; bbase = n_blk1;
    exp_field(K2, 256, 64, 1'b0, 1'b0);
    exp_field({128'h0, IV2}, 128, 64, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) exp_field({128'h0, D2[b]}, 128, 64, 1'b0, b == 2);
    toggle = 1'b1;
    send_cmd(0, K2, IV2, 1'b0, 16'd3);
    for (int b = 0; b < 3; b++) send_blk(0, D2[b]);
    wait_idle(0);
    toggle = 1'b0;
    step();
    check_frame("dec3", 0, base);
    check("dec3_tlast_count", 128'(n_last1 - lbase), 128'(1));
    check("dec3_blk_pulses",  128'(n_blk1 - bbase),  128'(3));

    // Zero-block command
    base = got64.size(); ebase = n_err1;
    send_cmd(0, K1, IV1, 1'b1, 16'd0);
    check("zero_err_pulse", 128'(err1),       128'(1));
    check("zero_cmd_ready", 128'(cmd_ready1), 128'(1));
    check("zero_tvalid",    128'(tvalid1),    128'(0));
    check("zero_busy",      128'(busy1),      128'(0));
    step();
    check("zero_err_clear", 128'(err1), 128'(0));
    check("zero_err_count", 128'(n_err1 - ebase), 128'(1));
    check("zero_no_beats",  128'(got64.size() - base), 128'(0));

    // Command held while busy: second frame must carry its own key
    base = got64.size();
    exp_field(K3, 256, 64, 1'b1, 1'b0);
    exp_field({128'h0, IV3}, 128, 64, 1'b1, 1'b0);
    exp_field({128'h0, DA}, 128, 64, 1'b1, 1'b1);
    exp_field(K4, 256, 64, 1'b0, 1'b0);
    exp_field({128'h0, IV4}, 128, 64, 1'b0, 1'b0);
    exp_field({128'h0, DB}, 128, 64, 1'b0, 1'b1);
    send_cmd(0, K3, IV3, 1'b1, 16'd1);
    fork
      send_blk(0, DA);
      send_cmd(0, K4, IV4, 1'b0, 16'd1);
    join
    send_blk(0, DB);
    wait_idle(0);
    check_frame("busycmd", 0, base);
    check("busy_cmd_ready_viol", 128'(busy_viol), 128'(0));

    // Reset while IV beat 1 is presented
    base = got64.size(); lbase = n_last1;
    send_cmd(0, K1, IV1, 1'b1, 16'd2);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (got64.size() - base == 5) ok = 1'b1;
      else step();
    end
    check("midrst_reach_iv1", 128'(ok), 128'(1));
    check("midrst_iv1_data", 128'(tdata1), 128'(64'h0001020304050607));
    rst = 1'b1;
    step();
    check("midrst_tvalid", 128'(tvalid1), 128'(0));
    check("midrst_busy",   128'(busy1),   128'(0));
    check("midrst_tlast",  128'(tlast1),  128'(0));
    rst = 1'b0;
    #1;
    check("midrst_cmd_ready", 128'(cmd_ready1), 128'(1));
    step(); step(); step();
    check("midrst_no_tlast", 128'(n_last1 - lbase), 128'(0));
    check("midrst_beats",    128'(got64.size() - base), 128'(5));

    // 128-bit beats, two blocks
    base = got128.size();
    exp_field(K5_SEL(), 256, 128, 1'b1, 1'b0);
    exp_field({128'h0, IV2}, 128, 128, 1'b1, 1'b0);
    exp_field({128'h0, X0}, 128, 128, 1'b1, 1'b0);
    exp_field({128'h0, X1}, 128, 128, 1'b1, 1'b1);
    send_cmd(1, K5_SEL(), IV2, 1'b1, 16'd2);
    send_blk(1, X0);
    send_blk(1, X1);
    wait_idle(1);
    check_frame("w128", 1, base);

    check("keep_viol_64",  128'(keep_viol1), 128'(0));
    check("keep_viol_128", 128'(keep_viol2), 128'(0));
    check("stall_hold",    128'(stall_viol), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic [255:0] K5_SEL();
    return K1;
  endfunction

endmodule
